screen_select_seq: RTL and testbench

- Parametrised, registered successor to the TicTacToe screen multiplexer. Picks one of NUM_SCREENS screen generators (rgb + font/ROM address) by fixed priority and drives the shared ROM address and VGA colour path.
- Selection changes take effect only at frame boundaries, so the picture never tears mid-frame.
- A screen change can insert a configurable number of background-colour frames.

---
 rtl/screen_select_seq.sv | 141 ++++++++++++++
 tb/tb_screen_select_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_select_seq.sv
// Frame-synchronous screen selector: picks the highest-priority enabled screen source,
// switches only on frame_start, and can insert background frames between screens.
module screen_select_seq #(
    parameter int unsigned        NUM_SCREENS  = 4,
    parameter int unsigned        RGB_W        = 3,
    parameter int unsigned        ADDR_W       = 11,
    parameter logic [RGB_W-1:0]   BG_COLOR     = 3'b001,
    parameter int unsigned        BLANK_FRAMES = 1,
    localparam int unsigned       IDX_W        = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SCREENS-1:0]        ce,
    input  logic [NUM_SCREENS*RGB_W-1:0]  rgb_in,
    input  logic [NUM_SCREENS*ADDR_W-1:0] addr_in,
    input  logic                          frame_start,
    input  logic                          video_on,
    output logic [RGB_W-1:0]              rgb,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic [IDX_W-1:0]              active_idx,
    output logic                          active_valid,
    output logic                          switching
);

    localparam int unsigned CNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CntInit =
        CNT_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]  req_idx;
    logic              req_valid;
    logic [RGB_W-1:0]  pix_rgb, rgb_d;
    logic [ADDR_W-1:0] pix_addr, rom_addr_d;

    // Scan downwards so the lowest enabled index is the last (winning) assignment.
    always_comb begin
        req_idx   = '0;
        req_valid = |ce;
        for (int i = int'(NUM_SCREENS) - 1; i >= 0; i--) begin
            if (ce[i]) req_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_idx_d  = sel_idx_q;
        pend_idx_d = pend_idx_q;
        cnt_d      = cnt_q;
        if (frame_start) begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        state_d   = StShow;
                        sel_idx_d = req_idx;
                    end
                end
                StShow: begin
                    if (!req_valid) begin
                        state_d = StIdle;
                    end else if (req_idx != sel_idx_q) begin
                        if (BLANK_FRAMES == 0) begin
                            sel_idx_d = req_idx;
                        end else begin
                            state_d    = StBlank;
                            pend_idx_d = req_idx;
                            cnt_d      = CntInit;
                        end
                    end
                end
                StBlank: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (req_valid) pend_idx_d = req_idx;
                    end else if (req_valid) begin
                        state_d   = StShow;
                        sel_idx_d = req_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        pix_rgb  = '0;
        pix_addr = '0;
        for (int i = 0; i < int'(NUM_SCREENS); i++) begin
            if (sel_idx_q == IDX_W'(i)) begin
                pix_rgb  = rgb_in[i*RGB_W +: RGB_W];
                pix_addr = addr_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pixel path follows the pre-update state; the new selection appears one cycle later.
    always_comb begin
        rgb_d      = '0;
        rom_addr_d = '0;
        if (video_on) begin
            if (state_q == StShow) begin
                rgb_d      = pix_rgb;
                rom_addr_d = pix_addr;
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            sel_idx_q    <= '0;
            pend_idx_q   <= '0;
            cnt_q        <= '0;
            rgb          <= '0;
            rom_addr     <= '0;
            active_idx   <= '0;
            active_valid <= 1'b0;
            switching    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_idx_q    <= sel_idx_d;
            pend_idx_q   <= pend_idx_d;
            cnt_q        <= cnt_d;
            rgb          <= rgb_d;
            rom_addr     <= rom_addr_d;
            active_idx   <= sel_idx_d;
            active_valid <= (state_d == StShow);
            switching    <= (state_d == StBlank);
        end
    end

endmodule

// File: tb/tb_screen_select_seq.sv
// Directed bench for screen_select_seq: a BLANK_FRAMES=2 instance and a BLANK_FRAMES=0
// instance share the same stimulus.
module tb_screen_select_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ce;
    logic [11:0] rgb_in;
    logic [43:0] addr_in;
    logic        frame_start;
    logic        video_on;

    logic [2:0]  rgb, rgb_b;
    logic [10:0] rom_addr, rom_addr_b;
    logic [1:0]  active_idx, active_idx_b;
    logic        active_valid, active_valid_b;
    logic        switching, switching_b;

    int n_cmp = 0;
    int n_err = 0;
    logic sw_b_seen = 1'b0;

    screen_select_seq #(
        .NUM_SCREENS(4), .RGB_W(3), .ADDR_W(11), .BG_COLOR(3'b001), .BLANK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .rgb_in(rgb_in), .addr_in(addr_in),
        .frame_start(frame_start), .video_on(video_on), .rgb(rgb), .rom_addr(rom_addr),
        .active_idx(active_idx), .active_valid(active_valid), .switching(switching)
    );

    screen_select_seq #(
        .NUM_SCREENS(4), .RGB_W(3), .ADDR_W(11), .BG_COLOR(3'b001), .BLANK_FRAMES(0)
    ) dut_b (
        .clk(clk), .reset(reset), .ce(ce), .rgb_in(rgb_in), .addr_in(addr_in),
        .frame_start(frame_start), .video_on(video_on), .rgb(rgb_b), .rom_addr(rom_addr_b),
        .active_idx(active_idx_b), .active_valid(active_valid_b), .switching(switching_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!reset && switching_b) sw_b_seen <= 1'b1;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 4'b0000; video_on = 1'b1; frame_start = 1'b0;
        tick(2);
        n_cmp++;
        if ({rgb, rom_addr, active_idx, active_valid, switching} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rgb=%0h addr=%0h idx=%0d av=%0b sw=%0b want all 0",
                     rgb, rom_addr, active_idx, active_valid, switching);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (rgb !== 3'b001) begin
            n_err++; $display("FAIL idle_bg_after_reset: got %0h want 1", rgb);
        end
    endtask

    task automatic test_idle();
        for (int f = 0; f < 3; f++) begin
            pulse();
            tick(3);
            n_cmp++;
            if (rgb !== 3'b001 || rom_addr !== 11'h0 || active_valid !== 1'b0) begin
                n_err++;
                $display("FAIL idle_frame%0d: got rgb=%0h addr=%0h av=%0b want 1/0/0",
                         f, rgb, rom_addr, active_valid);
            end
        end
    endtask

    task automatic test_show();
        tick(2);
        ce = 4'b0100;
        tick(3);
        n_cmp++;
        if (active_valid !== 1'b0 || rgb !== 3'b001) begin
            n_err++;
            $display("FAIL show_midframe_hold: got av=%0b rgb=%0h want 0/1", active_valid, rgb);
        end
        pulse();
        n_cmp++;
        if (active_valid !== 1'b1 || active_idx !== 2'd2 || rgb !== 3'b001) begin
            n_err++;
            $display("FAIL show_enter: got av=%0b idx=%0d rgb=%0h want 1/2/1",
                     active_valid, active_idx, rgb);
        end
        tick();
        n_cmp++;
        if (rgb !== 3'd6 || rom_addr !== 11'h155) begin
            n_err++; $display("FAIL show_pixel: got %0h/%0h want 6/155", rgb, rom_addr);
        end
    endtask

    task automatic test_blank();
        ce = 4'b0110;
        tick();
        n_cmp++;
        if (active_valid !== 1'b1 || rgb !== 3'd6) begin
            n_err++; $display("FAIL blank_midframe_hold: got av=%0b rgb=%0h want 1/6",
                              active_valid, rgb);
        end
        for (int f = 0; f < 2; f++) begin
            pulse();
            n_cmp++;
            if (switching !== 1'b1 || active_valid !== 1'b0 || active_idx !== 2'd2) begin
                n_err++;
                $display("FAIL blank_frame%0d_status: got sw=%0b av=%0b idx=%0d want 1/0/2",
                         f, switching, active_valid, active_idx);
            end
            tick(2);
            n_cmp++;
            if (rgb !== 3'b001 || rom_addr !== 11'h0) begin
                n_err++; $display("FAIL blank_frame%0d_bg: got %0h/%0h want 1/0", f, rgb, rom_addr);
            end
        end
        pulse();
        n_cmp++;
        if (switching !== 1'b0 || active_valid !== 1'b1 || active_idx !== 2'd1) begin
            n_err++;
            $display("FAIL blank_exit: got sw=%0b av=%0b idx=%0d want 0/1/1",
                     switching, active_valid, active_idx);
        end
        tick();
        n_cmp++;
        if (rgb !== 3'd5 || rom_addr !== 11'h123) begin
            n_err++; $display("FAIL blank_exit_pixel: got %0h/%0h want 5/123", rgb, rom_addr);
        end
    endtask

    task automatic test_blank_retarget();
        ce = 4'b0100;
        pulse();
        tick();
        ce = 4'b0010;
        tick();
        pulse();
        ce = 4'b1000;
        tick();
        n_cmp++;
        if (switching !== 1'b1) begin
            n_err++; $display("FAIL retarget_still_blank: got sw=%0b want 1", switching);
        end
        pulse();
        n_cmp++;
        if (active_valid !== 1'b1 || active_idx !== 2'd3 || switching !== 1'b0) begin
            n_err++;
            $display("FAIL retarget_show3: got av=%0b idx=%0d sw=%0b want 1/3/0",
                     active_valid, active_idx, switching);
        end
        tick();
        n_cmp++;
        if (rgb !== 3'd4 || rom_addr !== 11'h7F0) begin
            n_err++; $display("FAIL retarget_pixel: got %0h/%0h want 4/7f0", rgb, rom_addr);
        end
        ce = 4'b0001;
        pulse();
        pulse();
        ce = 4'b0000;
        pulse();
        n_cmp++;
        if (active_valid !== 1'b0 || switching !== 1'b0) begin
            n_err++; $display("FAIL blank_to_idle: got av=%0b sw=%0b want 0/0",
                              active_valid, switching);
        end
        tick();
        n_cmp++;
        if (rgb !== 3'b001) begin
            n_err++; $display("FAIL blank_to_idle_bg: got %0h want 1", rgb);
        end
    endtask

    // A request back to the old screen still serves the full blanking.
    task automatic test_blank_same();
        ce = 4'b0001;
        pulse();
        ce = 4'b0010;
        pulse();
        ce = 4'b0001;
        pulse();
        n_cmp++;
        if (switching !== 1'b1 || active_idx !== 2'd0) begin
            n_err++; $display("FAIL blank_same_hold: got sw=%0b idx=%0d want 1/0",
                              switching, active_idx);
        end
        pulse();
        n_cmp++;
        if (active_valid !== 1'b1 || active_idx !== 2'd0) begin
            n_err++; $display("FAIL blank_same_exit: got av=%0b idx=%0d want 1/0",
                              active_valid, active_idx);
        end
    endtask

    task automatic test_video_off();
        tick();
        video_on = 1'b0;
        tick();
        n_cmp++;
        if (rgb !== 3'd0 || rom_addr !== 11'h0) begin
            n_err++; $display("FAIL video_off: got %0h/%0h want 0/0", rgb, rom_addr);
        end
        video_on = 1'b1;
        ce = 4'b0000;
        tick(2);
        n_cmp++;
        if (rgb !== 3'd7 || rom_addr !== 11'h0AA || active_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ce_drop_midframe: got %0h/%0h av=%0b want 7/0aa/1",
                     rgb, rom_addr, active_valid);
        end
    endtask

    task automatic test_no_blank();
        ce = 4'b0001;
        pulse();
        tick();
        ce = 4'b1000;
        tick();
        pulse();
        n_cmp++;
        if (active_idx_b !== 2'd3 || active_valid_b !== 1'b1 || switching_b !== 1'b0
            || rgb_b !== 3'd7) begin
            n_err++;
            $display("FAIL noblank_switch: got idx=%0d av=%0b sw=%0b rgb=%0h want 3/1/0/7",
                     active_idx_b, active_valid_b, switching_b, rgb_b);
        end
        tick();
        n_cmp++;
        if (rgb_b !== 3'd4 || rom_addr_b !== 11'h7F0) begin
            n_err++; $display("FAIL noblank_pixel: got %0h/%0h want 4/7f0", rgb_b, rom_addr_b);
        end
        n_cmp++;
        if (switching !== 1'b1) begin
            n_err++; $display("FAIL blank2_same_switch: got sw=%0b want 1", switching);
        end
    endtask

    task automatic test_reset_in_blank();
        n_cmp++;
        if (sw_b_seen !== 1'b0) begin
            n_err++; $display("FAIL noblank_never_switching: got %0b want 0", sw_b_seen);
        end
        reset = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_cmp++;
        if ({rgb, rom_addr, active_idx, active_valid, switching} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_in_blank: got rgb=%0h addr=%0h idx=%0d av=%0b sw=%0b want 0",
                     rgb, rom_addr, active_idx, active_valid, switching);
        end
        reset = 1'b0;
        ce = 4'b0000;
        tick();
        n_cmp++;
        if (active_valid !== 1'b0 || rgb !== 3'b001) begin
            n_err++; $display("FAIL post_reset_idle: got av=%0b rgb=%0h want 0/1",
                              active_valid, rgb);
        end
    endtask

    initial begin
        rgb_in  = {3'd4, 3'd6, 3'd5, 3'd7};
        addr_in = {11'h7F0, 11'h155, 11'h123, 11'h0AA};
        test_reset();
        test_idle();
        test_show();
        test_blank();
        test_blank_retarget();
        test_blank_same();
        test_video_off();
        test_no_blank();
        test_reset_in_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
